// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_e      : controller state encoding (idle / adding / result held)
//   DefaultWidth : default operand width for serial_adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StAdd  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth = 4;

endpackage

// File: rtl/serial_fa.sv
// 1-bit combinational full adder used as the serial adder's datapath.
// Ports:
//   x, y : addend bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module serial_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: accepts a, b and cin on a valid/ready handshake, adds them one
// bit per cycle (LSB first) through a single full adder, then holds sum/cout on a
// valid/ready output handshake until consumed.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output (two's-complement
// overflow of the last result).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand handshake (ready only when idle)
//   a, b, cin           : operands and carry-in
//   out_valid, out_ready: result handshake (valid only when done)
//   sum, cout           : result modulo 2^WIDTH and carry-out of the MSB
//   ovf                 : signed overflow (only with SERIAL_ADDER_OVF_EN)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_s, fa_co;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Operand registers shift right so bit 0 is always the bit being added.
  serial_fa u_fa (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        // Sum bits enter at the MSB; after WIDTH shifts bit 0 lands in sum_q[0].
        sum_d   = {fa_s, sum_q[WIDTH-1:1]};
        carry_d = fa_co;
        if (cnt_q == CntLast) begin
          cnt_d   = '0;
          cout_d  = fa_co;
`ifdef SERIAL_ADDER_OVF_EN
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ fa_co;
`endif
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=4): a cycle-level behavioural model
// (countdown + integer arithmetic) is compared against the DUT on every falling edge,
// with directed transactions checked against hand-computed literals.
// Define SERIAL_ADDER_OVF_EN to also exercise the ovf output.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Signed overflow of x+y+c from integer arithmetic.
  function automatic bit signed_ovf(input logic [W-1:0] x, input logic [W-1:0] y,
                                    input logic c);
    int s;
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    return (s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1)));
  endfunction

  // Behavioural model: result appears W edges after acceptance.
  bit           model_on = 1'b0;
  bit           m_in_ready = 1'b1;
  bit           m_out_valid = 1'b0;
  logic [W-1:0] m_sum = '0;
  bit           m_cout = 1'b0;
  bit           m_ovf = 1'b0;
  int           m_timer = 0;
  logic [W:0]   m_pend = '0;
  bit           m_pend_ovf = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      model_on    <= 1'b1;
      m_in_ready  <= 1'b1;
      m_out_valid <= 1'b0;
      m_sum       <= '0;
      m_cout      <= 1'b0;
      m_ovf       <= 1'b0;
      m_timer     <= 0;
    end else if (m_in_ready && in_valid) begin
      m_in_ready <= 1'b0;
      m_timer    <= W;
      m_pend     <= {1'b0, a} + {1'b0, b} + (W + 1)'(cin);
      m_pend_ovf <= signed_ovf(a, b, cin);
    end else if (m_timer > 0) begin
      m_timer <= m_timer - 1;
      if (m_timer == 1) begin
        m_out_valid <= 1'b1;
        m_sum       <= m_pend[W-1:0];
        m_cout      <= m_pend[W];
        m_ovf       <= m_pend_ovf;
      end
    end else if (m_out_valid && out_ready) begin
      m_out_valid <= 1'b0;
      m_in_ready  <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("cmp_in_ready", 32'(in_ready), 32'(m_in_ready));
      chk("cmp_out_valid", 32'(out_valid), 32'(m_out_valid));
      if (m_in_ready || m_out_valid) begin
        chk("cmp_sum", 32'(sum), 32'(m_sum));
        chk("cmp_cout", 32'(cout), 32'(m_cout));
`ifdef SERIAL_ADDER_OVF_EN
        chk("cmp_ovf", 32'(ovf), 32'(m_ovf));
`endif
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk("wait_idle", 32'(in_ready), 32'd1);
  endtask

  // One transaction with out_ready=1; literals pin both DUT and model.
  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c, input logic [W-1:0] exp_s, input logic exp_c,
                        input logic exp_o);
    int lat = 0;
    wait_idle();
    out_ready = 1'b1;
    a = x;
    b = y;
    cin = c;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && lat < 50) begin
      step();
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'(W));
    chk({name, "_sum"}, 32'(sum), 32'(exp_s));
    chk({name, "_cout"}, 32'(cout), 32'(exp_c));
    chk({name, "_model_sum"}, 32'(m_sum), 32'(exp_s));
`ifdef SERIAL_ADDER_OVF_EN
    chk({name, "_ovf"}, 32'(ovf), 32'(exp_o));
`else
    if (exp_o !== m_ovf) chk({name, "_model_ovf"}, 32'(m_ovf), 32'(exp_o));
`endif
    step();
    chk({name, "_in_ready_next"}, 32'(in_ready), 32'd1);
    chk({name, "_out_valid_next"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    int lat;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_sum", 32'(sum), 32'd0);
    chk("reset_cout", 32'(cout), 32'd0);

    run_op("add_3_5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0, 1'b1);
    run_op("wrap_f_1", 4'hF, 4'h1, 1'b0, 4'h0, 1'b1, 1'b0);
    run_op("f_f_cin", 4'hF, 4'hF, 1'b1, 4'hF, 1'b1, 1'b0);
    run_op("ovf_7_1", 4'h7, 4'h1, 1'b0, 4'h8, 1'b0, 1'b1);

    // Back-pressure: hold result for 3 DONE cycles; in_valid pulses while adding.
    wait_idle();
    out_ready = 1'b0;
    a = 4'd2;
    b = 4'd2;
    cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      in_valid = lat[0];
      a = W'($urandom);
      b = W'($urandom);
      step();
      lat++;
    end
    in_valid = 1'b0;
    chk("hold_latency", 32'(lat), 32'(W));
    for (int k = 0; k < 3; k++) begin
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_sum", 32'(sum), 32'd4);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_sum_kept", 32'(sum), 32'd4);

    // Reset on the second ADD cycle discards the partial result.
    wait_idle();
    a = 4'd5;
    b = 4'd6;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_sum", 32'(sum), 32'd0);
    run_op("after_rst_1_1", 4'd1, 4'd1, 1'b0, 4'd2, 1'b0, 1'b0);

    // Randomized traffic checked by the model every cycle.
    for (int i = 0; i < 600; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      a         = W'($urandom);
      b         = W'($urandom);
      cin       = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 79) == 0);
      step();
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < W + 3; i++) step();
    chk("final_idle", 32'(in_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
